// File: rtl/module_dsp_mac_pkg.sv
// Shared constants and types for the DSP multiply-accumulate responder:
// word widths, opmode field positions, X/Z select codes and named opmodes.
package module_dsp_mac_pkg;

  localparam int DSP_INS_W  = 44;
  localparam int DSP_OUTS_W = 84;

  localparam int A_W = 18;
  localparam int B_W = 18;
  localparam int M_W = 36;
  localparam int P_W = 48;

  // Opmode field positions
  localparam int OPM_X_LSB   = 0;
  localparam int OPM_Z_LSB   = 2;
  localparam int OPM_CIN_BIT = 5;
  localparam int OPM_SUB_BIT = 7;

  // Q17 rescale applied by the Z=P>>>17 path
  localparam int Q_SHIFT = 17;

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_AB   = 2'd3
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO  = 2'd0,
    Z_ZERO1 = 2'd1,
    Z_P     = 2'd2,
    Z_PSHR  = 2'd3
  } z_sel_e;

  localparam logic [7:0] DSP_OP_NOP  = 8'h00;
  localparam logic [7:0] DSP_OP_MUL  = 8'h01;
  localparam logic [7:0] DSP_OP_MAC  = 8'h09;
  localparam logic [7:0] DSP_OP_MSUB = 8'h89;

endpackage

// File: rtl/module_dsp_mac_if.sv
// Client <-> DSP bus: owner select, packed client operation words, and the
// broadcast {m, p} result plus the sticky overflow flag.
interface module_dsp_mac_if #(
  parameter int NCLIENTS = 2,
  parameter int OWNER_W  = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1
);
  import module_dsp_mac_pkg::*;

  logic [OWNER_W-1:0]            owner_sel;
  logic [NCLIENTS*DSP_INS_W-1:0] dsp_ins_flat_all;
  logic [DSP_OUTS_W-1:0]         dsp_outs_flat;
  logic                          p_ovf;

  modport master (
    output owner_sel,
    output dsp_ins_flat_all,
    input  dsp_outs_flat,
    input  p_ovf
  );

  modport slave (
    input  owner_sel,
    input  dsp_ins_flat_all,
    output dsp_outs_flat,
    output p_ovf
  );

endinterface

// File: rtl/module_dsp_mac_dsp_client_mux.sv
// dsp_client_mux: picks the owning client's 44-bit word out of the flat bus
// and splits it into opmode / a / b. Out-of-range owners read as a NOP word.
module module_dsp_mac_dsp_client_mux
  import module_dsp_mac_pkg::*;
#(
  parameter int NCLIENTS = 2,
  parameter int OWNER_W  = 1
) (
  input  logic [OWNER_W-1:0]            i_owner_sel,
  input  logic [NCLIENTS*DSP_INS_W-1:0] i_ins_flat,
  output logic [7:0]                    o_opmode,
  output logic signed [A_W-1:0]         o_a,
  output logic signed [B_W-1:0]         o_b
);

  logic [DSP_INS_W-1:0] w_word;

  // Owner decode: default to the all-zero idle word
  always_comb begin
    w_word = {DSP_OP_NOP, {(A_W+B_W){1'b0}}};
    for (int k = 0; k < NCLIENTS; k++) begin
      if (i_owner_sel == OWNER_W'(k)) begin
        w_word = i_ins_flat[k*DSP_INS_W +: DSP_INS_W];
      end
    end
  end

  assign o_opmode = w_word[DSP_INS_W-1 -: 8];
  assign o_a      = w_word[A_W+B_W-1 -: A_W];
  assign o_b      = w_word[B_W-1:0];

endmodule

// File: rtl/module_dsp_mac.sv
// Shared fixed-point MAC responder: S1 input register, S2 multiply register,
// S3 48-bit post-add/accumulate with a sticky signed-overflow flag.
// Build option DSP_MREG_EN: when defined, S2 is a real register (m=2, p=3
// cycle latency); when undefined, S2 is combinational (m=1, p=2).
module module_dsp_mac
  import module_dsp_mac_pkg::*;
#(
  parameter int NCLIENTS = 2,
  parameter int OWNER_W  = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1
) (
  input logic             clk,
  input logic             reset_n,
  module_dsp_mac_if.slave bus
);

  function automatic logic signed [P_W-1:0] f_sext48(input logic signed [M_W-1:0] v);
    return {{(P_W-M_W){v[M_W-1]}}, v};
  endfunction

  function automatic logic signed [P_W-1:0] f_q17_rescale(input logic signed [P_W-1:0] v);
    return v >>> Q_SHIFT;
  endfunction

  // Exact (non-wrapping) result, two guard bits above the 48-bit range
  function automatic logic signed [P_W+1:0] f_exact(input logic signed [P_W-1:0] z,
                                                    input logic signed [P_W-1:0] x,
                                                    input logic cin,
                                                    input logic sub);
    logic signed [P_W+1:0] zx;
    logic signed [P_W+1:0] xx;
    zx = {{2{z[P_W-1]}}, z};
    xx = {{2{x[P_W-1]}}, x} + {{(P_W+1){1'b0}}, cin};
    return sub ? (zx - xx) : (zx + xx);
  endfunction

  function automatic logic f_ovf48(input logic signed [P_W+1:0] v);
    return !((v[P_W+1] == v[P_W]) && (v[P_W] == v[P_W-1]));
  endfunction

  logic [7:0]              w_op_p0;
  logic signed [A_W-1:0]   w_a_p0;
  logic signed [B_W-1:0]   w_b_p0;

  logic [7:0]              r_op_p1;
  logic signed [A_W-1:0]   r_a_p1;
  logic signed [B_W-1:0]   r_b_p1;
  logic signed [M_W-1:0]   w_prod_p1;
  logic signed [M_W-1:0]   w_ab_p1;

  logic [7:0]              w_op_p2;
  logic signed [M_W-1:0]   w_m_p2;
  logic signed [M_W-1:0]   w_ab_p2;

  logic signed [P_W-1:0]   w_x_p2;
  logic signed [P_W-1:0]   w_z_p2;
  logic signed [P_W+1:0]   w_exact_p2;
  logic                    w_ovf_p2;
  logic                    w_clr_p2;

  logic signed [P_W-1:0]   r_p_p3;
  logic                    r_ovf_p3;

  logic                    w_unused_rsvd;

  module_dsp_mac_dsp_client_mux #(
    .NCLIENTS (NCLIENTS),
    .OWNER_W  (OWNER_W)
  ) u_client_mux (
    .i_owner_sel (bus.owner_sel),
    .i_ins_flat  (bus.dsp_ins_flat_all),
    .o_opmode    (w_op_p0),
    .o_a         (w_a_p0),
    .o_b         (w_b_p0)
  );

  // ---- S1: input register ----
  // Capture the owning client's word every cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op_p1 <= '0;
      r_a_p1  <= '0;
      r_b_p1  <= '0;
    end else begin
      r_op_p1 <= w_op_p0;
      r_a_p1  <= w_a_p0;
      r_b_p1  <= w_b_p0;
    end
  end

  assign w_prod_p1 = M_W'(r_a_p1) * M_W'(r_b_p1);
  assign w_ab_p1   = {r_a_p1, r_b_p1};

  // ---- S2: multiply register ----
`ifdef DSP_MREG_EN
  logic [7:0]            r_op_p2;
  logic signed [M_W-1:0] r_m_p2;
  logic signed [M_W-1:0] r_ab_p2;

  // Register product, opmode and concatenated A:B
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op_p2 <= '0;
      r_m_p2  <= '0;
      r_ab_p2 <= '0;
    end else begin
      r_op_p2 <= r_op_p1;
      r_m_p2  <= w_prod_p1;
      r_ab_p2 <= w_ab_p1;
    end
  end

  assign w_op_p2 = r_op_p2;
  assign w_m_p2  = r_m_p2;
  assign w_ab_p2 = r_ab_p2;
`else
  assign w_op_p2 = r_op_p1;
  assign w_m_p2  = w_prod_p1;
  assign w_ab_p2 = w_ab_p1;
`endif

  // Opmode bits 4 and 6 are reserved
  assign w_unused_rsvd = ^{w_op_p2[6], w_op_p2[4]};

  // Decode X/Z operands and form the exact post-adder result
  always_comb begin
    w_x_p2 = '0;
    w_z_p2 = '0;
    case (x_sel_e'(w_op_p2[OPM_X_LSB +: 2]))
      X_M:     w_x_p2 = f_sext48(w_m_p2);
      X_P:     w_x_p2 = r_p_p3;
      X_AB:    w_x_p2 = f_sext48(w_ab_p2);
      default: w_x_p2 = '0;
    endcase
    case (z_sel_e'(w_op_p2[OPM_Z_LSB +: 2]))
      Z_P:     w_z_p2 = r_p_p3;
      Z_PSHR:  w_z_p2 = f_q17_rescale(r_p_p3);
      default: w_z_p2 = '0;
    endcase
    w_exact_p2 = f_exact(w_z_p2, w_x_p2, w_op_p2[OPM_CIN_BIT], w_op_p2[OPM_SUB_BIT]);
    w_ovf_p2   = f_ovf48(w_exact_p2);
    // X=0, Z in {0,1}, add: the clear op
    w_clr_p2   = (w_op_p2[OPM_X_LSB +: 2] == X_ZERO) && !w_op_p2[OPM_Z_LSB+1]
                 && !w_op_p2[OPM_SUB_BIT];
  end

  // ---- S3: P register ----
  // Wrap P mod 2^48; overflow sets the sticky flag, only the clear op drops it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p_p3   <= '0;
      r_ovf_p3 <= 1'b0;
    end else begin
      r_p_p3   <= w_exact_p2[P_W-1:0];
      r_ovf_p3 <= w_ovf_p2 | (r_ovf_p3 & ~w_clr_p2);
    end
  end

  assign bus.dsp_outs_flat = {w_m_p2, r_p_p3};
  assign bus.p_ovf         = r_ovf_p3;

endmodule

// File: tb/tb_module_dsp_mac.sv
// Bench for module_dsp_mac: a word is issued every cycle; a spec-level model
// predicts m/p/p_ovf and queues them with the edge they must appear after.
// A negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_module_dsp_mac;
  import module_dsp_mac_pkg::*;

  localparam int NCL = 3;
  localparam int OWW = 2;
`ifdef DSP_MREG_EN
  localparam int LAT_M = 2;
  localparam int LAT_P = 3;
`else
  localparam int LAT_M = 1;
  localparam int LAT_P = 2;
`endif

  localparam longint PMAX = (longint'(1) <<< 47) - 1;
  localparam longint PMIN = -(longint'(1) <<< 47);

  typedef struct {
    int     tag;
    longint val;
    bit     ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   edge_cnt = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  exp_t   q_m[$];
  exp_t   q_p[$];
  longint mdl_p = 0;
  bit     mdl_ovf = 1'b0;

  module_dsp_mac_if #(.NCLIENTS(NCL), .OWNER_W(OWW)) bus ();

  module_dsp_mac #(.NCLIENTS(NCL), .OWNER_W(OWW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Interpret the low 'bits' bits of v as a signed two's-complement number
  function automatic longint sx(input longint v, input int bits);
    longint r;
    r = v & ((longint'(1) <<< bits) - 1);
    if (r >= (longint'(1) <<< (bits - 1))) r = r - (longint'(1) <<< bits);
    return r;
  endfunction

  function automatic logic [43:0] mk(input logic [7:0] op, input int a, input int b);
    logic [31:0] ua;
    logic [31:0] ub;
    ua = a;
    ub = b;
    return {op, ua[17:0], ub[17:0]};
  endfunction

  // Behavioural model of one accepted word
  task automatic model_step(input logic [43:0] word, input int tag);
    logic [7:0] opm;
    longint a, b, m, ab, x, z, cin, exact;
    bit ovf, clr;
    exp_t e;
    opm = word[43:36];
    a   = sx(longint'(word[35:18]), 18);
    b   = sx(longint'(word[17:0]), 18);
    ab  = sx(longint'(word[35:0]), 36);
    m   = a * b;
    case (opm[1:0])
      2'd0: x = 0;
      2'd1: x = m;
      2'd2: x = mdl_p;
      default: x = ab;
    endcase
    case (opm[3:2])
      2'd2: z = mdl_p;
      2'd3: z = mdl_p >>> 17;
      default: z = 0;
    endcase
    cin   = opm[5] ? 1 : 0;
    exact = opm[7] ? (z - (x + cin)) : (z + x + cin);
    ovf   = (exact > PMAX) || (exact < PMIN);
    clr   = (opm[1:0] == 2'd0) && (opm[3:2] < 2'd2) && !opm[7];
    if (ovf) mdl_ovf = 1'b1;
    else if (clr) mdl_ovf = 1'b0;
    mdl_p = sx(exact, 48);
    e.tag = tag + LAT_M; e.val = m;     e.ovf = 1'b0;    q_m.push_back(e);
    e.tag = tag + LAT_P; e.val = mdl_p; e.ovf = mdl_ovf; q_p.push_back(e);
  endtask

  // Present one cycle of client words; called #1 after an active edge
  task automatic issue(input int sel, input logic [43:0] w0, input logic [43:0] w1,
                       input logic [43:0] w2);
    logic [31:0] us;
    logic [43:0] w;
    us = sel;
    bus.owner_sel        = us[1:0];
    bus.dsp_ins_flat_all = {w2, w1, w0};
    case (sel)
      0: w = w0;
      1: w = w1;
      2: w = w2;
      default: w = 44'd0;
    endcase
    model_step(w, edge_cnt);
    @(posedge clk); #1;
  endtask

  task automatic issue0(input logic [43:0] w);
    issue(0, w, 44'd0, 44'd0);
  endtask

  // Monitor: reset state while reset is held, scoreboard otherwise
  always @(negedge clk) begin : mon
    exp_t   e;
    longint got;
    if (!reset_n) begin
      n_cmp++;
      if (bus.dsp_outs_flat !== 84'h0 || bus.p_ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_zero: got outs=%h ovf=%b, required 0/0", bus.dsp_outs_flat, bus.p_ovf);
      end
    end else begin
      while (q_m.size() > 0 && q_m[0].tag <= edge_cnt) begin
        e = q_m.pop_front();
        n_cmp++;
        got = sx(longint'(bus.dsp_outs_flat[83:48]), 36);
        if (e.tag != edge_cnt) begin
          n_fail++;
          $display("FAIL m_missed: tag=%0d at edge %0d", e.tag, edge_cnt);
        end else if (got != e.val) begin
          n_fail++;
          $display("FAIL m edge=%0d: got %0d, required %0d", edge_cnt, got, e.val);
        end
      end
      while (q_p.size() > 0 && q_p[0].tag <= edge_cnt) begin
        e = q_p.pop_front();
        n_cmp++;
        got = sx(longint'(bus.dsp_outs_flat[47:0]), 48);
        if (e.tag != edge_cnt) begin
          n_fail++;
          $display("FAIL p_missed: tag=%0d at edge %0d", e.tag, edge_cnt);
        end else if (got != e.val || bus.p_ovf !== e.ovf) begin
          n_fail++;
          $display("FAIL p/ovf edge=%0d: got p=%0d ovf=%b, required p=%0d ovf=%b",
                   edge_cnt, got, bus.p_ovf, e.val, e.ovf);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [43:0] w0, w1, w2;
    bus.owner_sel        = '0;
    bus.dsp_ins_flat_all = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Multiply 3 * -5
    issue0(mk(DSP_OP_MUL, 3, -5));
    repeat (3) issue0(mk(DSP_OP_NOP, 0, 0));

    // Back-to-back MAC 2*2 from zero
    issue0(mk(DSP_OP_NOP, 0, 0));
    repeat (4) issue0(mk(DSP_OP_MAC, 2, 2));
    issue0(mk(DSP_OP_MSUB, 1, 3));

    // Subtract with carry, then Q17 rescale
    issue0(mk(DSP_OP_MUL, 10, 10));
    issue0(mk(8'hA9, 2, 5));
    issue0(mk(8'h03, 1, 1 << 17));
    issue0(mk(8'h0C, 0, 0));
    repeat (2) issue0(mk(DSP_OP_NOP, 0, 0));

    // Owner interleave, then out-of-range and third client
    for (int i = 0; i < 6; i++)
      issue(i % 2, mk(DSP_OP_MUL, 7, 6), mk(DSP_OP_MUL, -4, 4), mk(DSP_OP_MUL, 9, 9));
    issue(3, mk(DSP_OP_MUL, 7, 6), mk(DSP_OP_MUL, -4, 4), mk(DSP_OP_MUL, 9, 9));
    issue(2, mk(DSP_OP_MUL, 7, 6), mk(DSP_OP_MUL, -4, 4), mk(DSP_OP_MUL, 9, 9));

    // Build P = 2^47-1 by P=2P+1, overflow with +1, sticky through MAC, clear
    issue0(mk(DSP_OP_NOP, 0, 0));
    repeat (47) issue0(mk(8'h2A, 0, 0));
    issue0(mk(8'h28, 0, 0));
    repeat (2) issue0(mk(DSP_OP_MAC, 1, 1));
    issue0(mk(DSP_OP_NOP, 0, 0));
    repeat (2) issue0(mk(DSP_OP_MAC, 1, 1));

    // Reset in the middle of a MAC run with overflow flag set
    issue0(mk(DSP_OP_NOP, 0, 0));
    repeat (47) issue0(mk(8'h2A, 0, 0));
    issue0(mk(8'h28, 0, 0));
    repeat (3) issue0(mk(DSP_OP_MAC, 5, 7));
    reset_n = 1'b0;
    q_m.delete();
    q_p.delete();
    mdl_p   = 0;
    mdl_ovf = 1'b0;
    bus.dsp_ins_flat_all = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) issue0(mk(DSP_OP_NOP, 0, 0));
    repeat (3) issue0(mk(DSP_OP_MAC, -3, 3));

    // Randomized traffic across all owners, including out-of-range
    for (int i = 0; i < 400; i++) begin
      w0 = {$urandom, $urandom};
      w1 = {$urandom, $urandom};
      w2 = {$urandom, $urandom};
      if (i % 37 == 0) w0 = mk(DSP_OP_NOP, 0, 0);
      issue($urandom_range(0, 3), w0, w1, w2);
    end

    repeat (LAT_P + 2) issue0(mk(DSP_OP_NOP, 0, 0));
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/module_dsp_mac.md
# module_dsp_mac

Shared fixed-point multiply-accumulate responder: the DSP-side end of the `dsp_ins_flat`/`dsp_outs_flat` interface used by the synth calculation modules (LPF coefficient calculator, Taylor ALU, IIR).

- Accepts one 44-bit operation word per cycle from the client chosen by `owner_sel`.
- Runs a pipelined 18x18 multiply and 48-bit post-add/accumulate.
- Broadcasts the 84-bit `{m, p}` result word to all clients.

## Interface

Parameters:

- `NCLIENTS`, default 2: number of client operation ports.
- `OWNER_W`, default `$clog2(NCLIENTS)` (minimum 1): width of `owner_sel`.

Ports:

- `clk`  in  1: the single clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `owner_sel`  in  `OWNER_W`: client whose operation word is sampled this cycle.
- `dsp_ins_flat_all`  in  `NCLIENTS*44`: packed client words.
  - Client k occupies bits [k*44+43 : k*44].
  - Each word is `{opmode[7:0], a[17:0], b[17:0]}`; `a` and `b` are signed.
- `dsp_outs_flat`  out  84: `{m[35:0], p[47:0]}`, both signed.
- `p_ovf`  out  1: sticky signed-overflow flag of `p`.

## Operation

Stage S1 (input register):

- Every cycle, registers A1, B1 and OP1 from client `owner_sel`.
- An out-of-range `owner_sel` selects all-zero (NOP).

Stage S2 (multiply register, present when `DSP_MREG_EN` is defined):

- M2 = A1*B1, full 36-bit signed product.
- OP2 = OP1.
- AB2 = sext36({A1,B1}).

Stage S3 (P register), opmode decode taken from the S2 copy:

- [1:0] X select:
  - 0: zero
  - 1: sext48(M2)
  - 2: P
  - 3: sext48(AB2)
- [3:2] Z select:
  - 0 and 1: zero
  - 2: P
  - 3: P >>> 17 (arithmetic shift, Q17 rescale)
- [5] carry-in: `cin` = bit 5.
- [7] subtract:
  - 0: P <= Z + X + cin
  - 1: P <= Z - (X + cin)
- Bits [4] and [6] are reserved and ignored.

Arithmetic rules:

- All arithmetic is two's complement, wrapping mod 2^48.
- `m` output = M2; `p` output = P.

`p_ovf` behaviour:

- Set on any S3 update whose exact result lies outside the signed 48-bit range.
- Cleared only by an S3 op with X=0, Z=0 and bit 7 = 0 (clear op, e.g. 8'h00).
- If a clear op also overflows, set wins (not possible with the defined encodings).

Other rules:

- An all-zero word (8'h00) loads P=0; it is also the idle word clients drive when not owner.
- There is no stall or backpressure: one operation per cycle is always accepted.
- `owner_sel` is sampled in S1 together with the data. Switching owner every cycle is legal, and each client's op completes in order.
- P feedback uses the current P register, so consecutive X=M/Z=P ops accumulate back-to-back with no bubble.
- Reset asserted mid-operation clears all pipeline registers, `m`, `p` and `p_ovf` immediately; in-flight operations are discarded.

## Timing

- Reset value of every register and output is 0: `dsp_outs_flat` = 84'h0 and `p_ovf` = 0.
- A word presented before edge N (sampled at edge N) produces:
  - `m` after edge N+1;
  - `p` and `p_ovf` after edge N+2.
- Client latency is therefore 2 cycles for `m` and 3 cycles for `p`, counted as visible 2 and 3 cycles after presentation.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

## Configuration

`DSP_MREG_EN`:

- Defined: S2 register exists, latency is m=2 and p=3, and the block matches the DSP48A1 MREG=1 timing the client sequencers are written for.
- Undefined: M2, OP2 and AB2 are combinational from S1. Latency drops to m=1 and p=2, and accumulation semantics are unchanged.

## Structure

- Shared package/header (`globals.vh`) holds:
  - `DSP_INS_W`=44, `DSP_OUTS_W`=84;
  - the opmode field positions;
  - the X and Z select codes;
  - named opmodes `DSP_OP_NOP`=8'h00, `DSP_OP_MUL`=8'h01, `DSP_OP_MAC`=8'h09 and `DSP_OP_MSUB`=8'h89.
- One sub-module, `dsp_client_mux`, holds the `owner_sel` decode and the unpacking of the flat word into S1 fields.

## Test plan

- Reset: assert `reset_n`=0 mid-MAC -> outputs 0 immediately; after release with idle words, `p` stays 0 and `p_ovf`=0.
- Multiply: 8'h01, a=3, b=-5 -> m=-15 two cycles later, p=-15 three cycles later.
- MAC: 8'h00, then four back-to-back 8'h09 with a=b=2 -> p sequence 4, 8, 12, 16 on consecutive cycles.
- Subtract with carry: P=100, then 8'hA9 with a=2, b=5 -> p=89. Then 8'h0C (Z=P>>>17) with P=3<<17 -> p=3.
- Owner interleave, NCLIENTS=2, `owner_sel` toggling each cycle:
  - Client 0 sends 8'h01 with 7*6.
  - Client 1 sends 8'h01 with -4*4.
  - Expected: p alternates 42, -16; an out-of-range select yields p=0.
- Overflow: P=48'h7FFF_FFFF_FFFF, then 8'h28 -> p=48'h8000_0000_0000 and `p_ovf`=1; `p_ovf` holds through 8'h09, and 8'h00 clears it. Repeat the multiply test with `DSP_MREG_EN` undefined -> latency m=1, p=2.
